// File: rtl/msx_fdc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : msx_fdc_ctrl
// Description : MSX floppy-cartridge glue logic for an external WD1793 core
//               and disk ROM. It decodes slot accesses into the ROM window
//               and the 7FF8-7FFF register window, captures CPU writes
//               synchronously, latches per-drive media presence and turns the
//               motor off after a period with no FDC activity.
//
// Parameters  : DRIVES      - number of drives (1..4); higher codes never ready
//               LAYOUT      - 0: DRQ/INTRQ read inverted, 1: read active-high
//               MOTOR_TICKS - clk_en ticks with no FDC access before motor off
//
// Ports       : clk, reset_n (async, active-low), clk_en (CPU-rate tick)
//               addr, d_from_cpu, d_to_cpu, sltsl_n, cs1_n, rd_n, wr_n - CPU bus
//               fdd_enable              - gates register writes and fdc_ready
//               rom_cs, rom_data        - disk ROM interface
//               fdc_cs, fdc_rd, fdc_wr, fdc_addr, fdc_dout, fdc_drq,
//               fdc_intrq, fdc_side, fdc_ready - WD1793 interface
//               drive_sel, motor_on     - drive control state
//               img_mounted, img_size   - image mount notification
//
// Build macro : MSX_FDC_DISKCHG_EN - adds per-drive disk-changed flags read at
//               7FFE and cleared by reading them.
//
// Revision    : 1.0 - initial release
// ============================================================================
module msx_fdc_ctrl #(
    parameter int DRIVES      = 2,
    parameter int LAYOUT      = 0,
    parameter int MOTOR_TICKS = 7159090
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clk_en,
    input  logic [15:0]       addr,
    input  logic [7:0]        d_from_cpu,
    output logic [7:0]        d_to_cpu,
    input  logic              sltsl_n,
    input  logic              cs1_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              fdd_enable,
    output logic              rom_cs,
    input  logic [7:0]        rom_data,
    output logic              fdc_cs,
    output logic              fdc_rd,
    output logic              fdc_wr,
    output logic [1:0]        fdc_addr,
    input  logic [7:0]        fdc_dout,
    input  logic              fdc_drq,
    input  logic              fdc_intrq,
    output logic              fdc_side,
    output logic              fdc_ready,
    output logic [1:0]        drive_sel,
    output logic              motor_on,
    input  logic [DRIVES-1:0] img_mounted,
    input  logic [31:0]       img_size
);

    localparam logic [23:0] c_MOTOR_TICKS = 24'(MOTOR_TICKS);
    localparam logic [2:0]  c_DRIVES      = 3'(DRIVES);

    typedef enum logic [0:0] {
        MOTOR_OFF = 1'b0,
        MOTOR_ON  = 1'b1
    } motor_state_t;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic w_page1;
    logic w_win;
    logic w_sel_side;
    logic w_sel_drv;
    logic w_sel_chg;
    logic w_sel_stat;

    assign w_page1    = (addr[15:14] == 2'b01);
    assign w_win      = ~sltsl_n & w_page1 & (&addr[13:3]);
    assign w_sel_side = w_win & (addr[2:0] == 3'd4);
    assign w_sel_drv  = w_win & (addr[2:0] == 3'd5);
    assign w_sel_chg  = w_win & (addr[2:0] == 3'd6);
    assign w_sel_stat = w_win & (addr[2:0] == 3'd7);

    assign fdc_cs   = w_win & ~addr[2];
    // The register window takes precedence over the ROM, even with cs1_n low.
    assign rom_cs   = ~sltsl_n & ~cs1_n & w_page1 & ~w_win;
    assign fdc_rd   = fdc_cs & ~rd_n;
    assign fdc_wr   = fdc_cs & ~wr_n;
    assign fdc_addr = addr[1:0];

    // ------------------------------------------------------------------
    // Write capture: one commit per strobe, on its first low clock
    // ------------------------------------------------------------------
    logic       r_wr_q;
    logic       r_side;
    logic [1:0] r_drive_sel;
    logic       w_commit;
    logic       w_motor_wr;

    assign w_commit   = ~wr_n & ~r_wr_q & (w_sel_side | w_sel_drv) & fdd_enable;
    assign w_motor_wr = w_commit & w_sel_drv;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_q      <= 1'b0;
            r_side      <= 1'b0;
            r_drive_sel <= 2'd0;
        end else begin
            r_wr_q <= ~wr_n;
            if (w_commit && w_sel_side) begin
                r_side <= d_from_cpu[0];
            end
            if (w_motor_wr) begin
                r_drive_sel <= d_from_cpu[1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Motor watchdog
    // ------------------------------------------------------------------
    motor_state_t r_state;
    motor_state_t w_state_nxt;
    logic [23:0]  r_count;
    logic [23:0]  w_count_nxt;
    logic         r_acc_q;
    logic         w_acc_edge;

    // Only the leading edge of an FDC access re-arms the timer, so a CPU
    // parked on an FDC register does not keep the motor spinning forever.
    assign w_acc_edge = (fdc_rd | fdc_wr) & ~r_acc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= MOTOR_OFF;
            r_count <= 24'd0;
            r_acc_q <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_acc_q <= fdc_rd | fdc_wr;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            MOTOR_OFF: begin
                if (w_motor_wr && d_from_cpu[7]) begin
                    w_state_nxt = MOTOR_ON;
                    w_count_nxt = c_MOTOR_TICKS;
                end
            end
            MOTOR_ON: begin
                if (w_motor_wr && !d_from_cpu[7]) begin
                    w_state_nxt = MOTOR_OFF;
                    w_count_nxt = 24'd0;
                end else if (w_motor_wr || w_acc_edge) begin
                    // A reload takes priority over a tick in the same cycle.
                    w_count_nxt = c_MOTOR_TICKS;
                end else if (clk_en) begin
                    if (r_count <= 24'd1) begin
                        w_state_nxt = MOTOR_OFF;
                        w_count_nxt = 24'd0;
                    end else begin
                        w_count_nxt = r_count - 24'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = MOTOR_OFF;
                w_count_nxt = 24'd0;
            end
        endcase
    end

    assign motor_on  = (r_state == MOTOR_ON);
    assign fdc_side  = r_side;
    assign drive_sel = r_drive_sel;

    // ------------------------------------------------------------------
    // Media-present latches
    // ------------------------------------------------------------------
    logic [DRIVES-1:0] r_present;
    logic [3:0]        w_present4;
    logic              w_drive_ok;

    for (genvar i = 0; i < DRIVES; i++) begin : g_present
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_present[i] <= 1'b0;
            end else if (img_mounted[i]) begin
                r_present[i] <= |img_size;
            end
        end
    end

    // Zero-padded to four entries so any 2-bit drive code indexes safely.
    assign w_present4 = 4'(r_present);
    assign w_drive_ok = ({1'b0, r_drive_sel} < c_DRIVES);
    assign fdc_ready  = fdd_enable & motor_on & w_drive_ok & w_present4[r_drive_sel];

    // ------------------------------------------------------------------
    // Disk-changed flags (optional)
    // ------------------------------------------------------------------
    logic [7:0] w_chg_rd;

`ifdef MSX_FDC_DISKCHG_EN
    logic [DRIVES-1:0] r_changed;
    logic [3:0]        w_changed4;
    logic              r_rd_q;
    logic              w_rd_fall;

    assign w_rd_fall = ~rd_n & ~r_rd_q & w_sel_chg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_q <= 1'b0;
        end else begin
            r_rd_q <= ~rd_n;
        end
    end

    for (genvar i = 0; i < DRIVES; i++) begin : g_changed
        localparam logic [1:0] c_IDX = 2'(i);
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_changed[i] <= 1'b0;
            end else if (img_mounted[i]) begin
                // A mount in the same clock as the clearing read wins.
                r_changed[i] <= 1'b1;
            end else if (w_rd_fall && (r_drive_sel == c_IDX)) begin
                r_changed[i] <= 1'b0;
            end
        end
    end

    assign w_changed4 = 4'(r_changed);
    assign w_chg_rd   = {7'h7F, ~w_changed4[r_drive_sel]};
`else
    assign w_chg_rd   = 8'hFF;
`endif

    // ------------------------------------------------------------------
    // CPU read mux
    // ------------------------------------------------------------------
    always_comb begin
        d_to_cpu = 8'hFF;
        if (rom_cs) begin
            d_to_cpu = rom_data;
        end else if (fdc_rd) begin
            d_to_cpu = fdc_dout;
        end else if (w_sel_side) begin
            d_to_cpu = {7'h7F, ~r_side};
        end else if (w_sel_drv) begin
            d_to_cpu = {motor_on, 5'b11111, r_drive_sel};
        end else if (w_sel_stat) begin
            if (LAYOUT == 0) begin
                d_to_cpu = {~fdc_drq, ~fdc_intrq, 6'h3F};
            end else begin
                d_to_cpu = {fdc_drq, fdc_intrq, 6'h3F};
            end
        end else if (w_sel_chg) begin
            d_to_cpu = w_chg_rd;
        end
    end

    // Data bits [6:2] carry no register meaning at 7FFD.
    logic w_unused;
    assign w_unused = &{1'b0, d_from_cpu[6:2]};

endmodule
`default_nettype wire

// File: tb/tb_msx_fdc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_msx_fdc_ctrl
// Description : Self-checking bench for msx_fdc_ctrl (DRIVES=2, LAYOUT=0,
//               MOTOR_TICKS=10). Decode/read-mux vectors come from a table;
//               multi-cycle behaviour uses hand-written sequences. Expected
//               values are queued as stimulus is driven and compared when the
//               DUT output is sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msx_fdc_ctrl;

    localparam int DRIVES      = 2;
    localparam int MOTOR_TICKS = 10;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              clk_en;
    logic [15:0]       addr;
    logic [7:0]        d_from_cpu;
    logic [7:0]        d_to_cpu;
    logic              sltsl_n;
    logic              cs1_n;
    logic              rd_n;
    logic              wr_n;
    logic              fdd_enable;
    logic              rom_cs;
    logic [7:0]        rom_data;
    logic              fdc_cs;
    logic              fdc_rd;
    logic              fdc_wr;
    logic [1:0]        fdc_addr;
    logic [7:0]        fdc_dout;
    logic              fdc_drq;
    logic              fdc_intrq;
    logic              fdc_side;
    logic              fdc_ready;
    logic [1:0]        drive_sel;
    logic              motor_on;
    logic [DRIVES-1:0] img_mounted;
    logic [31:0]       img_size;

    msx_fdc_ctrl #(
        .DRIVES      (DRIVES),
        .LAYOUT      (0),
        .MOTOR_TICKS (MOTOR_TICKS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clk_en      (clk_en),
        .addr        (addr),
        .d_from_cpu  (d_from_cpu),
        .d_to_cpu    (d_to_cpu),
        .sltsl_n     (sltsl_n),
        .cs1_n       (cs1_n),
        .rd_n        (rd_n),
        .wr_n        (wr_n),
        .fdd_enable  (fdd_enable),
        .rom_cs      (rom_cs),
        .rom_data    (rom_data),
        .fdc_cs      (fdc_cs),
        .fdc_rd      (fdc_rd),
        .fdc_wr      (fdc_wr),
        .fdc_addr    (fdc_addr),
        .fdc_dout    (fdc_dout),
        .fdc_drq     (fdc_drq),
        .fdc_intrq   (fdc_intrq),
        .fdc_side    (fdc_side),
        .fdc_ready   (fdc_ready),
        .drive_sel   (drive_sel),
        .motor_on    (motor_on),
        .img_mounted (img_mounted),
        .img_size    (img_size)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        string      name;
        logic [7:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic sb_push(input string name, input logic [7:0] exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [7:0] act);
        sb_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL scoreboard_empty actual=%h", act);
        end else begin
            e = sb_q.pop_front();
            if (act !== e.exp) begin
                n_errors++;
                $display("FAIL %s actual=%h expected=%h", e.name, act, e.exp);
            end
        end
    endtask

    // Push the expectation, let the DUT settle, then compare.
    task automatic chk(input string name, input logic [7:0] exp);
        sb_push(name, exp);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Bus tasks (all driving happens on the falling edge)
    // ------------------------------------------------------------------
    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input int hold);
        @(negedge clk);
        addr       = a;
        d_from_cpu = d;
        wr_n       = 1'b0;
        @(negedge clk);
        // Different data for the rest of the strobe exposes a repeated commit.
        d_from_cpu = 8'h00;
        repeat (hold - 1) @(negedge clk);
        wr_n = 1'b1;
        addr = 16'h0000;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a;
        rd_n = 1'b0;
        #1;
        d = d_to_cpu;
        @(negedge clk);
        rd_n = 1'b1;
        addr = 16'h0000;
    endtask

    task automatic mount(input logic [DRIVES-1:0] m, input logic [31:0] s);
        @(negedge clk);
        img_mounted = m;
        img_size    = s;
        @(negedge clk);
        img_mounted = '0;
    endtask

    // ------------------------------------------------------------------
    // Decode / read-mux vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [15:0] addr;
        logic        sltsl_n;
        logic        cs1_n;
        logic        rd_n;
        logic        drq;
        logic        intrq;
        logic [7:0]  rom_data;
        logic [7:0]  fdc_dout;
        logic [7:0]  exp_dout;
        logic        exp_rom_cs;
        logic        exp_fdc_cs;
        logic        exp_fdc_rd;
    } vec_t;

    vec_t vecs[15];

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [7:0] rd;

        reset_n     = 1'b0;
        clk_en      = 1'b0;
        addr        = 16'h0000;
        d_from_cpu  = 8'h00;
        sltsl_n     = 1'b0;
        cs1_n       = 1'b1;
        rd_n        = 1'b1;
        wr_n        = 1'b1;
        fdd_enable  = 1'b0;
        rom_data    = 8'h00;
        fdc_dout    = 8'h00;
        fdc_drq     = 1'b0;
        fdc_intrq   = 1'b0;
        img_mounted = '0;
        img_size    = 32'd0;

        //           addr     sl cs rd dq iq rom    fdc    exp    rcs fcs frd
        vecs[0]  = '{16'h7FFC, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 0, 0, 0};
        vecs[1]  = '{16'h7FFD, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h7C, 0, 0, 0};
        vecs[2]  = '{16'h7FFF, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 0, 0, 0};
        vecs[3]  = '{16'h7FFF, 0, 1, 0, 1, 0, 8'h00, 8'h00, 8'h7F, 0, 0, 0};
        vecs[4]  = '{16'h7FFF, 0, 1, 0, 0, 1, 8'h00, 8'h00, 8'hBF, 0, 0, 0};
        vecs[5]  = '{16'h7FFF, 0, 1, 0, 1, 1, 8'h00, 8'h00, 8'h3F, 0, 0, 0};
        vecs[6]  = '{16'h5000, 0, 0, 0, 0, 0, 8'hA5, 8'h00, 8'hA5, 1, 0, 0};
        vecs[7]  = '{16'h5000, 0, 1, 0, 0, 0, 8'hA5, 8'h00, 8'hFF, 0, 0, 0};
        vecs[8]  = '{16'h7FF9, 0, 1, 0, 0, 0, 8'h00, 8'h3C, 8'h3C, 0, 1, 1};
        vecs[9]  = '{16'h7FF9, 0, 1, 1, 0, 0, 8'h00, 8'h3C, 8'hFF, 0, 1, 0};
        vecs[10] = '{16'h7FFC, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 0, 0, 0};
        vecs[11] = '{16'h7FF8, 0, 0, 0, 0, 0, 8'h5A, 8'hC3, 8'hC3, 0, 1, 1};
        vecs[12] = '{16'h3FFC, 0, 0, 0, 0, 0, 8'h11, 8'h00, 8'hFF, 0, 0, 0};
        vecs[13] = '{16'h7FFE, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 0, 0, 0};
        vecs[14] = '{16'hBFFC, 0, 0, 0, 0, 0, 8'h22, 8'h00, 8'hFF, 0, 0, 0};

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("reset_side", 8'd0);       sb_check({7'd0, fdc_side});
        chk("reset_ready", 8'd0);      sb_check({7'd0, fdc_ready});
        chk("reset_motor", 8'd0);      sb_check({7'd0, motor_on});
        chk("reset_drive_sel", 8'd0);  sb_check({6'd0, drive_sel});
        reset_n = 1'b1;

        // ---------------- decode table ----------------
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            addr      = vecs[i].addr;
            sltsl_n   = vecs[i].sltsl_n;
            cs1_n     = vecs[i].cs1_n;
            rd_n      = vecs[i].rd_n;
            fdc_drq   = vecs[i].drq;
            fdc_intrq = vecs[i].intrq;
            rom_data  = vecs[i].rom_data;
            fdc_dout  = vecs[i].fdc_dout;
            sb_push($sformatf("vec%0d_dout", i), vecs[i].exp_dout);
            sb_push($sformatf("vec%0d_rom_cs", i), {7'd0, vecs[i].exp_rom_cs});
            sb_push($sformatf("vec%0d_fdc_cs", i), {7'd0, vecs[i].exp_fdc_cs});
            sb_push($sformatf("vec%0d_fdc_rd", i), {7'd0, vecs[i].exp_fdc_rd});
            sb_push($sformatf("vec%0d_fdc_addr", i), {6'd0, vecs[i].addr[1:0]});
            #1;
            sb_check(d_to_cpu);
            sb_check({7'd0, rom_cs});
            sb_check({7'd0, fdc_cs});
            sb_check({7'd0, fdc_rd});
            sb_check({6'd0, fdc_addr});
        end
        @(negedge clk);
        addr      = 16'h0000;
        sltsl_n   = 1'b0;
        cs1_n     = 1'b1;
        rd_n      = 1'b1;
        fdc_drq   = 1'b0;
        fdc_intrq = 1'b0;

        // ---------------- writes gated by fdd_enable ----------------
        cpu_write(16'h7FFC, 8'h01, 1);
        chk("gated_side", 8'd0);       sb_check({7'd0, fdc_side});
        cpu_write(16'h7FFD, 8'h81, 1);
        chk("gated_motor", 8'd0);      sb_check({7'd0, motor_on});

        // ---------------- held strobe commits once ----------------
        fdd_enable = 1'b1;
        cpu_write(16'h7FFD, 8'h81, 5);
        chk("held_drive_sel", 8'd1);   sb_check({6'd0, drive_sel});
        chk("held_motor", 8'd1);       sb_check({7'd0, motor_on});
        chk("unmounted_ready", 8'd0);  sb_check({7'd0, fdc_ready});
        cpu_read(16'h7FFD, rd);
        chk("read_7ffd", 8'hFD);       sb_check(rd);

        // ---------------- media present / ready ----------------
        mount(2'b10, 32'd737280);
        chk("ready_drive1", 8'd1);     sb_check({7'd0, fdc_ready});
        cpu_write(16'h7FFD, 8'h83, 1);
        chk("sel_drive3", 8'd3);       sb_check({6'd0, drive_sel});
        chk("ready_drive3", 8'd0);     sb_check({7'd0, fdc_ready});
        cpu_write(16'h7FFC, 8'h01, 1);
        chk("side_set", 8'd1);         sb_check({7'd0, fdc_side});
        cpu_read(16'h7FFC, rd);
        chk("read_7ffc", 8'hFE);       sb_check(rd);
        cpu_write(16'h7FFD, 8'h80, 1);
        chk("ready_drive0_empty", 8'd0); sb_check({7'd0, fdc_ready});
        mount(2'b01, 32'd0);
        chk("ready_zero_size", 8'd0);  sb_check({7'd0, fdc_ready});
        mount(2'b01, 32'd1474560);
        chk("ready_drive0", 8'd1);     sb_check({7'd0, fdc_ready});
        fdd_enable = 1'b0;
        chk("ready_disabled", 8'd0);   sb_check({7'd0, fdc_ready});
        fdd_enable = 1'b1;
        mount(2'b11, 32'd0);
        chk("ready_dual_unmount0", 8'd0); sb_check({7'd0, fdc_ready});
        cpu_write(16'h7FFD, 8'h81, 1);
        chk("ready_dual_unmount1", 8'd0); sb_check({7'd0, fdc_ready});

        // ---------------- motor off by write ----------------
        cpu_write(16'h7FFD, 8'h01, 1);
        chk("motor_write_off", 8'd0);  sb_check({7'd0, motor_on});

        // ---------------- watchdog: no access ----------------
        clk_en = 1'b1;
        @(negedge clk);
        addr = 16'h7FFD; d_from_cpu = 8'h80; wr_n = 1'b0;
        @(negedge clk);
        wr_n = 1'b1; addr = 16'h0000;
        chk("wd_start", 8'd1);         sb_check({7'd0, motor_on});
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("wd_tick%0d", k), (k < 10) ? 8'd1 : 8'd0);
            sb_check({7'd0, motor_on});
        end

        // ---------------- watchdog: access at tick 8 extends ----------------
        @(negedge clk);
        addr = 16'h7FFD; d_from_cpu = 8'h80; wr_n = 1'b0;
        @(negedge clk);
        wr_n = 1'b1; addr = 16'h0000;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 8) begin
                rd_n = 1'b1; addr = 16'h0000;
            end
            chk($sformatf("wd_ext_tick%0d", k), (k < 18) ? 8'd1 : 8'd0);
            sb_check({7'd0, motor_on});
            if (k == 7) begin
                addr = 16'h7FF8; rd_n = 1'b0;
            end
        end
        clk_en = 1'b0;

        // ---------------- disk changed ----------------
        mount(2'b01, 32'd1474560);
        cpu_read(16'h7FFE, rd);
`ifdef MSX_FDC_DISKCHG_EN
        chk("chg_first_read", 8'hFE);  sb_check(rd);
`else
        chk("chg_first_read", 8'hFF);  sb_check(rd);
`endif
        cpu_read(16'h7FFE, rd);
        chk("chg_second_read", 8'hFF); sb_check(rd);

        // ---------------- asynchronous reset mid-ON ----------------
        cpu_write(16'h7FFD, 8'h81, 1);
        chk("pre_reset_motor", 8'd1);  sb_check({7'd0, motor_on});
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        chk("async_reset_motor", 8'd0);     sb_check({7'd0, motor_on});
        chk("async_reset_drive_sel", 8'd0); sb_check({6'd0, drive_sel});
        chk("async_reset_side", 8'd0);      sb_check({7'd0, fdc_side});
        @(negedge clk);
        reset_n = 1'b1;
        mount(2'b00, 32'd0);
        cpu_read(16'h7FFE, rd);
        chk("post_reset_7ffe", 8'hFF); sb_check(rd);
        chk("post_reset_ready", 8'd0); sb_check({7'd0, fdc_ready});

        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_leftover actual=%0d expected=0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
